// File: rtl/ks_regs_pkg.sv
// Register map, control-bit positions and identification constants shared by
// the bus responder and its register file.
package ks_regs_pkg;

   localparam logic [7:0]  TXQCR_ADDR = 8'h80;
   localparam logic [7:0]  RXQCR_ADDR = 8'h82;
   localparam logic [7:0]  IER_ADDR   = 8'h90;
   localparam logic [7:0]  ISR_ADDR   = 8'h92;
   localparam logic [7:0]  CIDER_ADDR = 8'hC0;

   localparam int METFE_BIT = 0;
   localparam int SDA_BIT   = 3;
   localparam int TXIS_BIT  = 14;

   localparam logic [15:0] CHIP_ID_DEFAULT = 16'h8870;
   localparam logic [12:0] TXCNT_MAX       = 13'h1FFF;

   function automatic logic [15:0] be_mask(input logic [1:0] be);
      return {{8{be[1]}}, {8{be[0]}}};
   endfunction

endpackage

// File: rtl/ks_regfile.sv
// 128x16 word storage with byte-lane write enables and direct taps on the
// control registers the responder needs every cycle.
module ks_regfile
   import ks_regs_pkg::*;
(
   input  logic        clk40m,
   input  logic        reset,
   input  logic        we_i,
   input  logic [6:0]  waddr_i,
   input  logic [15:0] wdata_i,
   input  logic [1:0]  wbe_i,
   input  logic [6:0]  raddr_i,
   output logic [15:0] rdata_o,
   output logic [15:0] ier_o,
   output logic [15:0] txqcr_o,
   output logic [15:0] rxqcr_o
);

   logic [15:0] mem_q [128];
   logic [15:0] lane_m;

   assign lane_m = be_mask(wbe_i);

   always_ff @(posedge clk40m or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 128; i++) mem_q[i] <= '0;
      end else if (we_i) begin
         mem_q[waddr_i] <= (mem_q[waddr_i] & ~lane_m) | (wdata_i & lane_m);
      end
   end

   assign rdata_o = mem_q[raddr_i];
   assign ier_o   = mem_q[IER_ADDR[7:1]];
   assign txqcr_o = mem_q[TXQCR_ADDR[7:1]];
   assign rxqcr_o = mem_q[RXQCR_ADDR[7:1]];

endmodule

// File: rtl/ks_bus_responder.sv
// Host-bus responder: strobe edge decode, address/data cycles, DMA word capture,
// frame-end handling and the registered interrupt output.
module ks_bus_responder
   import ks_regs_pkg::*;
#(
   parameter logic [15:0] CHIP_ID = CHIP_ID_DEFAULT
) (
   input  logic        clk40m,
   input  logic        reset,
   input  logic        CSN,
   input  logic        CMD,
   input  logic        RDN,
   input  logic        WRN,
   input  logic [15:0] SD_in,
   output logic [15:0] SD_out,
   output logic        SD_oe,
   output logic        INTRN,
   output logic        frame_done,
   output logic [12:0] tx_word_count,
   output logic        proto_err
);

   logic        armed_q, rdn_q, wrn_q;
   logic [7:0]  addr_q, addr_d;
   logic [1:0]  be_q, be_d;
   logic        oe_q, oe_d;
   logic [15:0] sd_out_q, sd_out_d;
   logic        intrn_q, intrn_d;
   logic        frame_done_q;
   logic        proto_err_q, proto_err_d;
   logic [12:0] txcnt_q, txcnt_d;
   logic [15:0] isr_q, isr_d;
   logic        metfe_q, metfe_d;

   logic        both_low, wr_fall, rd_fall, addr_wr, data_wr, data_rd;
   logic        hit_txqcr, hit_rxqcr, hit_ier, hit_isr, hit_cider, special;
   logic        dma_wr, reg_wr;
   logic        rf_we;
   logic [6:0]  rf_waddr;
   logic [15:0] rf_wdata, rf_rdata, rd_word;
   logic [1:0]  rf_wbe;
   logic [15:0] ier, txqcr, rxqcr;

   ks_regfile u_regfile (
      .clk40m  (clk40m),
      .reset   (reset),
      .we_i    (rf_we),
      .waddr_i (rf_waddr),
      .wdata_i (rf_wdata),
      .wbe_i   (rf_wbe),
      .raddr_i (addr_q[7:1]),
      .rdata_o (rf_rdata),
      .ier_o   (ier),
      .txqcr_o (txqcr),
      .rxqcr_o (rxqcr)
   );

   always_comb begin
      both_low  = ~CSN & ~RDN & ~WRN;
      // armed_q masks the first cycle after reset so a strobe already low is not an edge
      wr_fall   = armed_q & wrn_q & ~WRN & ~CSN & ~both_low;
      rd_fall   = armed_q & rdn_q & ~RDN & ~CSN & ~both_low;
      addr_wr   = wr_fall & CMD;
      data_wr   = wr_fall & ~CMD;
      data_rd   = rd_fall & ~CMD;

      hit_txqcr = (addr_q == TXQCR_ADDR);
      hit_rxqcr = (addr_q == RXQCR_ADDR);
      hit_ier   = (addr_q == IER_ADDR);
      hit_isr   = (addr_q == ISR_ADDR);
      hit_cider = (addr_q == CIDER_ADDR);
      special   = hit_txqcr | hit_rxqcr | hit_ier | hit_isr | hit_cider;

      // Named registers stay reachable in DMA mode so the host can end the frame,
      // service the interrupt and leave DMA mode.
      dma_wr    = data_wr & rxqcr[SDA_BIT] & ~special;
      reg_wr    = data_wr & ~dma_wr;
      metfe_d   = reg_wr & hit_txqcr & be_q[0] & SD_in[METFE_BIT];

      rf_we     = (reg_wr & ~hit_cider & ~hit_isr) | metfe_q;
      rf_waddr  = addr_q[7:1];
      rf_wdata  = SD_in;
      rf_wbe    = be_q;
      if (metfe_q) begin
         rf_waddr            = TXQCR_ADDR[7:1];
         rf_wdata            = txqcr;
         rf_wdata[METFE_BIT] = 1'b0;
         rf_wbe              = 2'b11;
      end

      rd_word = rf_rdata;
      if (hit_cider)    rd_word = CHIP_ID;
      else if (hit_isr) rd_word = isr_q;

      addr_d = addr_q;
      be_d   = be_q;
      if (addr_wr) begin
         addr_d = {SD_in[7:1], 1'b0};
         be_d   = SD_in[13:12];
      end

      isr_d = isr_q;
      if (reg_wr & hit_isr) isr_d = isr_q & ~(SD_in & be_mask(be_q));
      if (metfe_q)          isr_d[TXIS_BIT] = 1'b1;

      txcnt_d = txcnt_q;
      if (metfe_q)                            txcnt_d = '0;
      else if (dma_wr && txcnt_q != TXCNT_MAX) txcnt_d = txcnt_q + 13'd1;

      oe_d     = oe_q;
      sd_out_d = sd_out_q;
      if (data_rd) begin
         oe_d     = 1'b1;
         sd_out_d = rd_word;
      end else if (oe_q & RDN) begin
         oe_d     = 1'b0;
         sd_out_d = '0;
      end

      proto_err_d = proto_err_q | both_low;
      intrn_d     = ~|(isr_q & ier);
   end

   always_ff @(posedge clk40m or posedge reset) begin
      if (reset) begin
         armed_q      <= 1'b0;
         rdn_q        <= 1'b1;
         wrn_q        <= 1'b1;
         addr_q       <= '0;
         be_q         <= 2'b11;
         oe_q         <= 1'b0;
         sd_out_q     <= '0;
         intrn_q      <= 1'b1;
         frame_done_q <= 1'b0;
         proto_err_q  <= 1'b0;
         txcnt_q      <= '0;
         isr_q        <= '0;
         metfe_q      <= 1'b0;
      end else begin
         armed_q      <= 1'b1;
         rdn_q        <= RDN;
         wrn_q        <= WRN;
         addr_q       <= addr_d;
         be_q         <= be_d;
         oe_q         <= oe_d;
         sd_out_q     <= sd_out_d;
         intrn_q      <= intrn_d;
         frame_done_q <= metfe_q;
         proto_err_q  <= proto_err_d;
         txcnt_q      <= txcnt_d;
         isr_q        <= isr_d;
         metfe_q      <= metfe_d;
      end
   end

   assign SD_out        = sd_out_q;
   assign SD_oe         = oe_q;
   assign INTRN         = intrn_q;
   assign frame_done    = frame_done_q;
   assign tx_word_count = txcnt_q;
   assign proto_err     = proto_err_q;

endmodule

// File: tb/tb_ks_bus_responder.sv
// Directed bench for ks_bus_responder: register access, byte lanes, DMA capture,
// frame end / interrupt, protocol error and mid-read reset.
`timescale 1ns/100ps
module tb_ks_bus_responder;

   logic        clk40m = 1'b0;
   logic        reset;
   logic        CSN, CMD, RDN, WRN;
   logic [15:0] SD_in;
   logic [15:0] SD_out;
   logic        SD_oe, INTRN, frame_done, proto_err;
   logic [12:0] tx_word_count;

   int checks   = 0;
   int failures = 0;

   ks_bus_responder dut (
      .clk40m        (clk40m),
      .reset         (reset),
      .CSN           (CSN),
      .CMD           (CMD),
      .RDN           (RDN),
      .WRN           (WRN),
      .SD_in         (SD_in),
      .SD_out        (SD_out),
      .SD_oe         (SD_oe),
      .INTRN         (INTRN),
      .frame_done    (frame_done),
      .tx_word_count (tx_word_count),
      .proto_err     (proto_err)
   );

   always #12.5 clk40m = ~clk40m;

   task automatic tick();
      @(posedge clk40m);
      #2;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic addr_cycle(input logic [15:0] v);
      CSN = 1'b0; CMD = 1'b1; SD_in = v; WRN = 1'b0;
      tick();
      WRN = 1'b1;
      tick();
      CSN = 1'b1;
   endtask

   task automatic data_write(input logic [15:0] d);
      CSN = 1'b0; CMD = 1'b0; SD_in = d; WRN = 1'b0;
      tick();
      WRN = 1'b1;
      tick();
      CSN = 1'b1;
   endtask

   task automatic data_read(input string tag, input logic [15:0] exp);
      CSN = 1'b0; CMD = 1'b0; RDN = 1'b0;
      tick();
      chk({tag, "_oe"}, {31'd0, SD_oe}, 32'd1);
      chk({tag, "_data"}, {16'd0, SD_out}, {16'd0, exp});
      tick();
      chk({tag, "_hold"}, {16'd0, SD_out}, {16'd0, exp});
      RDN = 1'b1;
      tick();
      chk({tag, "_oe_off"}, {31'd0, SD_oe}, 32'd0);
      CSN = 1'b1;
   endtask

   initial begin
      reset = 1'b1; CSN = 1'b1; CMD = 1'b0; RDN = 1'b1; WRN = 1'b1; SD_in = '0;
      tick(); tick();
      chk("rst_oe",    {31'd0, SD_oe},        32'd0);
      chk("rst_out",   {16'd0, SD_out},       32'd0);
      chk("rst_intrn", {31'd0, INTRN},        32'd1);
      chk("rst_fd",    {31'd0, frame_done},   32'd0);
      chk("rst_perr",  {31'd0, proto_err},    32'd0);
      chk("rst_cnt",   {19'd0, tx_word_count}, 32'd0);
      reset = 1'b0;
      tick(); tick();

      // No address cycle yet: address 0x00, both lanes
      data_write(16'hBEEF);
      data_read("default_addr", 16'hBEEF);

      addr_cycle(16'h3090);
      data_write(16'h1234);
      data_read("ier_rw", 16'h1234);
      chk("intrn_idle", {31'd0, INTRN}, 32'd1);

      addr_cycle(16'h30C0);
      data_read("cider", 16'h8870);
      data_write(16'hFFFF);
      data_read("cider_ro", 16'h8870);

      addr_cycle(16'h1090);
      data_write(16'hABCD);
      data_read("be_low", 16'h12CD);
      addr_cycle(16'h0090);
      data_write(16'h5555);
      data_read("be_none", 16'h12CD);

      // DMA burst and frame end
      addr_cycle(16'h3090);
      data_write(16'h4000);
      addr_cycle(16'h3082);
      data_write(16'h0008);
      addr_cycle(16'h3000);
      for (int i = 0; i < 65; i++) data_write(16'(i));
      chk("dma_cnt65", {19'd0, tx_word_count}, 32'd65);
      data_read("dma_bypass", 16'hBEEF);

      addr_cycle(16'h3080);
      CSN = 1'b0; CMD = 1'b0; SD_in = 16'h0001; WRN = 1'b0;
      tick();
      chk("metfe_fd_early", {31'd0, frame_done},    32'd0);
      chk("metfe_cnt_hold", {19'd0, tx_word_count}, 32'd65);
      WRN = 1'b1;
      tick();
      chk("metfe_fd",      {31'd0, frame_done},    32'd1);
      chk("metfe_cnt_clr", {19'd0, tx_word_count}, 32'd0);
      chk("metfe_intrn_lag", {31'd0, INTRN},       32'd1);
      CSN = 1'b1;
      tick();
      chk("metfe_fd_pulse", {31'd0, frame_done}, 32'd0);
      chk("metfe_intrn",    {31'd0, INTRN},      32'd0);
      addr_cycle(16'h3092);
      data_read("isr_txis", 16'h4000);
      addr_cycle(16'h3080);
      data_read("txqcr_selfclr", 16'h0000);
      addr_cycle(16'h3092);
      data_write(16'h4000);
      chk("isr_w1c_intrn", {31'd0, INTRN}, 32'd1);
      data_read("isr_w1c", 16'h0000);

      // Both strobes low together, then a deselected write
      addr_cycle(16'h3090);
      CSN = 1'b0; CMD = 1'b0; SD_in = 16'h1111; RDN = 1'b0; WRN = 1'b0;
      tick();
      RDN = 1'b1; WRN = 1'b1;
      tick();
      CSN = 1'b1;
      chk("perr_set", {31'd0, proto_err}, 32'd1);
      chk("perr_oe",  {31'd0, SD_oe},     32'd0);
      data_read("perr_nowrite", 16'h4000);
      CSN = 1'b1; CMD = 1'b0; SD_in = 16'h2222; WRN = 1'b0;
      tick();
      WRN = 1'b1;
      tick();
      data_read("csn_high", 16'h4000);
      chk("perr_sticky", {31'd0, proto_err}, 32'd1);

      // Counter saturation
      addr_cycle(16'h3000);
      for (int i = 0; i < 8200; i++) data_write(16'hA5A5);
      chk("cnt_sat", {19'd0, tx_word_count}, 32'd8191);
      addr_cycle(16'h3080);
      data_write(16'h0001);
      chk("sat_clr", {19'd0, tx_word_count}, 32'd0);
      tick();
      chk("intrn_again", {31'd0, INTRN}, 32'd0);
      addr_cycle(16'h3000);
      for (int i = 0; i < 5; i++) data_write(16'h0F0F);
      chk("cnt5", {19'd0, tx_word_count}, 32'd5);

      // Reset in the middle of a read
      addr_cycle(16'h3090);
      CSN = 1'b0; CMD = 1'b0; RDN = 1'b0;
      tick();
      chk("mid_oe", {31'd0, SD_oe}, 32'd1);
      #3 reset = 1'b1;
      #1;
      chk("mrst_oe",    {31'd0, SD_oe},         32'd0);
      chk("mrst_out",   {16'd0, SD_out},        32'd0);
      chk("mrst_intrn", {31'd0, INTRN},         32'd1);
      chk("mrst_cnt",   {19'd0, tx_word_count}, 32'd0);
      chk("mrst_perr",  {31'd0, proto_err},     32'd0);
      tick();
      reset = 1'b0;
      tick(); tick();
      chk("post_rst_no_edge", {31'd0, SD_oe}, 32'd0);
      RDN = 1'b1; CSN = 1'b1;
      tick();
      data_read("rst_storage", 16'h0000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ks_bus_responder.md
KS_BUS_RESPONDER -- requirements
Module: ks_bus_responder

Interface
REQ-001 SHALL have port clk40m, input, 1 bit: single clock for all logic.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port CSN, input, 1 bit: active-low chip select; when high, all strobes are ignored.
REQ-004 SHALL have port CMD, input, 1 bit: 1 = address cycle, 0 = data cycle.
REQ-005 SHALL have ports RDN and WRN, inputs, 1 bit each: active-low strobes, synchronous to clk40m, each at least 1 cycle low.
REQ-006 SHALL have port SD_in, input, 16 bits: bus value driven by the host.
REQ-007 SHALL have port SD_out, output, 16 bits: read data.
REQ-008 SHALL have port SD_oe, output, 1 bit: 1 = responder drives the bus.
REQ-009 SHALL have port INTRN, output, 1 bit: active-low interrupt.
REQ-010 SHALL have port frame_done, output, 1 bit: one-cycle pulse at end of a transmitted frame.
REQ-011 SHALL have port tx_word_count, output, 13 bits: words captured in the current frame.
REQ-012 SHALL have port proto_err, output, 1 bit: sticky protocol-error flag.
REQ-013 SHALL have parameter CHIP_ID, default 16'h8870: value returned by CIDER.

Function
REQ-014 SHALL detect strobe falling edges using the previous-cycle values of RDN and WRN; an access counts only if CSN=0 in the edge cycle.
REQ-015 Address cycle (CMD=1, WRN fall): SHALL latch addr <= {SD_in[7:1],0} and be <= SD_in[13:12] (bit0 = low byte, bit1 = high byte).
REQ-016 Data write (CMD=0, WRN fall): SHALL update the byte lanes of reg[addr] selected by be; an unselected lane SHALL be unchanged; be=00 SHALL be a no-op.
REQ-017 Data read (CMD=0, RDN fall): SHALL assert SD_oe and present reg[addr] on SD_out one cycle after the edge, hold both while RDN=0, and deassert SD_oe in the cycle after RDN rises.
REQ-018 Storage SHALL be 128x16 words indexed by addr[7:1], with these special registers:
 - CIDER 0xC0: read-only, returns CHIP_ID.
 - IER 0x90: plain read/write.
 - ISR 0x92: write-1-to-clear.
 - TXQCR 0x80: bit0 METFE self-clears one cycle after it is written as 1.
 - RXQCR 0x82: bit3 SDA selects DMA mode.
REQ-019 While RXQCR[3]=1, a data write SHALL bypass storage and increment tx_word_count; tx_word_count SHALL saturate at 8191.
REQ-020 A write of TXQCR[0]=1 SHALL, one cycle later:
 - pulse frame_done;
 - set ISR[14];
 - clear tx_word_count.
REQ-021 If ISR[14] is set and written-to-clear in the same cycle, the set SHALL win.
REQ-022 INTRN SHALL be registered: INTRN = ~|(ISR & IER), one cycle after either register changes.
REQ-023 RDN and WRN both low in the same cycle with CSN=0 SHALL be ignored and SHALL set proto_err; only reset clears proto_err.
REQ-024 A data cycle with no prior address cycle since reset SHALL use addr=0x00 and be=11.

Reset
REQ-025 reset SHALL, asynchronously:
 - clear storage, addr, and tx_word_count;
 - set be=11;
 - drive SD_oe=0, SD_out=0, INTRN=1, frame_done=0, proto_err=0.
REQ-026 Asserting reset mid-read SHALL release SD_oe immediately.
REQ-027 After reset deasserts, a strobe already low SHALL NOT count as an edge.

Structure
REQ-028 Register offsets, the bit positions (METFE, SDA, TXIS), and CHIP_ID SHALL live in shared package ks_regs_pkg.
REQ-029 Storage plus byte-enable write logic SHALL be sub-module ks_regfile; strobe decode, DMA capture, and interrupt logic SHALL stay in ks_bus_responder.

Verification
REQ-030 Write 0x1234 to 0x90 (address cycle SD=0x3090, then data write), then read 0x90 -> SD_out=0x1234 with SD_oe=1 one cycle after RDN falls.
REQ-031 Read 0xC0 -> 0x8870; then write 0xFFFF to 0xC0 and read again -> still 0x8870.
REQ-032 Address cycle with be=01 (SD=0x1090), write 0xABCD over 0x1234 -> read returns 0x12CD.
REQ-033 Set IER=0x4000, RXQCR=0x0008, write 65 data words, write TXQCR=0x0001:
 - tx_word_count=65 before the TXQCR write;
 - one cycle after the TXQCR write: frame_done pulses, tx_word_count=0, ISR[14]=1;
 - INTRN=0 one cycle after ISR[14] sets;
 - write 0x4000 to ISR -> INTRN=1.
REQ-034 Drive RDN=0 and WRN=0 together -> proto_err=1 and storage unchanged; hold CSN=1 and perform a write -> no change.
REQ-035 Assert reset while RDN is low mid-read -> SD_oe=0 in the same cycle, INTRN=1, tx_word_count=0.
